// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 controller: FSM states, init ROM, command constants
// and the clear/home classifier that selects the long busy wait.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } lcd_state_e;

  localparam int INIT_LEN   = 6;
  localparam int INIT_IDX_W = 3;

  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0, 3'd1, 3'd2: val = FUNC_SET_8B2L;
      3'd3:             val = DISP_ON;
      3'd4:             val = CLEAR;
      3'd5:             val = ENTRY_INC;
      default:          val = 8'h00;
    endcase
    return val;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Reloadable compare-to-zero down-counter; a start with load N raises done on the N-th cycle
// after the start edge, so the caller's state lasts exactly N cycles.
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             busy,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;
  logic             run_r;

  // Count down from load-1 and stop at zero without wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (start) begin
      cnt_r <= (load == '0) ? '0 : load - CNT_W'(1);
      run_r <= 1'b1;
    end else if (run_r && (cnt_r == '0)) begin
      cnt_r <= cnt_r;
      run_r <= 1'b0;
    end else if (run_r) begin
      cnt_r <= cnt_r - CNT_W'(1);
      run_r <= run_r;
    end else begin
      cnt_r <= cnt_r;
      run_r <= run_r;
    end
  end

  assign busy = run_r;
  assign done = run_r && (cnt_r == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write-only timing engine: runs the power-up init sequence, then writes one byte per
// valid/ready handshake with setup, enable pulse, hold and busy wait on the 8-bit bus.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 2_000_000,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 25,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2_500,
  parameter int CLR_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
  localparam int MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Power-up spends one cycle arming the counter, so the counted part is one shorter.
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_WAIT_CYC);
  localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

  lcd_state_e            state_r;
  lcd_state_e            state_nx_s;
  logic [INIT_IDX_W-1:0] init_idx_r;
  logic [INIT_IDX_W-1:0] init_idx_nx_s;
  logic                  init_done_r;
  logic                  init_done_nx_s;
  logic                  req_ready_r;
  logic                  req_ready_nx_s;
  logic [7:0]            lcd_data_r;
  logic [7:0]            lcd_data_nx_s;
  logic                  lcd_rs_r;
  logic                  lcd_rs_nx_s;
  logic                  lcd_en_r;
  logic                  lcd_en_nx_s;
  logic                  init_last_s;
  logic                  cnt_start_s;
  logic [CNT_W-1:0]      cnt_load_s;
  logic                  cnt_busy_s;
  logic                  cnt_done_s;

  assign init_last_s = (init_idx_r == INIT_LAST);

  lcd_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .start (cnt_start_s),
    .load  (cnt_load_s),
    .busy  (cnt_busy_s),
    .done  (cnt_done_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_PWRUP;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; every timed state leaves on the delay counter's done pulse
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_PWRUP:     state_nx_s = cnt_done_s ? ST_INIT_LOAD : ST_PWRUP;
      ST_INIT_LOAD: state_nx_s = ST_SETUP;
      ST_SETUP:     state_nx_s = cnt_done_s ? ST_PULSE : ST_SETUP;
      ST_PULSE:     state_nx_s = cnt_done_s ? ST_HOLD : ST_PULSE;
      ST_HOLD:      state_nx_s = cnt_done_s ? ST_WAIT : ST_HOLD;
      ST_WAIT: begin
        if (!cnt_done_s) begin
          state_nx_s = ST_WAIT;
        end else if (init_done_r || init_last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_INIT_LOAD;
        end
      end
      ST_IDLE:      state_nx_s = (req_valid && req_ready_r) ? ST_SETUP : ST_IDLE;
      default:      state_nx_s = ST_PWRUP;
    endcase
  end

  // Output and counter-control logic, evaluated against the upcoming state
  always_comb begin
    lcd_data_nx_s  = lcd_data_r;
    lcd_rs_nx_s    = lcd_rs_r;
    init_idx_nx_s  = init_idx_r;
    init_done_nx_s = init_done_r;
    cnt_start_s    = 1'b0;
    cnt_load_s     = '0;

    if (state_r == ST_INIT_LOAD) begin
      lcd_data_nx_s = init_rom(init_idx_r);
      lcd_rs_nx_s   = 1'b0;
    end else if ((state_r == ST_IDLE) && (state_nx_s == ST_SETUP)) begin
      lcd_data_nx_s = req_data;
      lcd_rs_nx_s   = req_rs;
    end else begin
      lcd_data_nx_s = lcd_data_r;
      lcd_rs_nx_s   = lcd_rs_r;
    end

    if ((state_r == ST_WAIT) && cnt_done_s && !init_done_r) begin
      if (init_last_s) begin
        init_done_nx_s = 1'b1;
      end else begin
        init_idx_nx_s = init_idx_r + INIT_IDX_W'(1);
      end
    end else begin
      init_idx_nx_s  = init_idx_r;
      init_done_nx_s = init_done_r;
    end

    if ((state_r == ST_PWRUP) && !cnt_busy_s) begin
      cnt_start_s = 1'b1;
      cnt_load_s  = LD_PWRUP;
    end else if (state_nx_s != state_r) begin
      case (state_nx_s)
        ST_SETUP: begin cnt_start_s = 1'b1; cnt_load_s = LD_SETUP; end
        ST_PULSE: begin cnt_start_s = 1'b1; cnt_load_s = LD_EN;    end
        ST_HOLD:  begin cnt_start_s = 1'b1; cnt_load_s = LD_HOLD;  end
        ST_WAIT: begin
          cnt_start_s = 1'b1;
          cnt_load_s  = is_clear_home(lcd_rs_r, lcd_data_r) ? LD_CLR : LD_CMD;
        end
        default: begin cnt_start_s = 1'b0; cnt_load_s = '0; end
      endcase
    end else begin
      cnt_start_s = 1'b0;
      cnt_load_s  = '0;
    end

    lcd_en_nx_s    = (state_nx_s == ST_PULSE);
    req_ready_nx_s = (state_nx_s == ST_IDLE) && init_done_nx_s;
  end

  // Output registers; async reset clears the enable strobe immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_idx_r  <= '0;
      init_done_r <= 1'b0;
      req_ready_r <= 1'b0;
      lcd_data_r  <= 8'h00;
      lcd_rs_r    <= 1'b0;
      lcd_en_r    <= 1'b0;
    end else begin
      init_idx_r  <= init_idx_nx_s;
      init_done_r <= init_done_nx_s;
      req_ready_r <= req_ready_nx_s;
      lcd_data_r  <= lcd_data_nx_s;
      lcd_rs_r    <= lcd_rs_nx_s;
      lcd_en_r    <= lcd_en_nx_s;
    end
  end

  assign req_ready = req_ready_r;
  assign init_done = init_done_r;
  assign lcd_data  = lcd_data_r;
  assign lcd_rs    = lcd_rs_r;
  assign lcd_en    = lcd_en_r;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl with shortened timing: a scoreboard queue of
// expected bus writes is checked by a pulse monitor, plus a table of request vectors.
module tb_lcd_hd44780_ctrl;

  localparam int PWRUP = 20;
  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int HOLD  = 2;
  localparam int CMDW  = 10;
  localparam int CLRW  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_cyc;
  } vec_t;

  exp_t mon_q[$];

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC    (PWRUP),
    .SETUP_CYC    (SETUP),
    .EN_CYC       (EN),
    .HOLD_CYC     (HOLD),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected init writes; gap = low cycles between pulses = hold + wait + load + setup.
  task automatic push_init();
    logic [7:0] rom [6];
    int         prev_wait;
    rom[0] = 8'h38; rom[1] = 8'h38; rom[2] = 8'h38;
    rom[3] = 8'h0C; rom[4] = 8'h01; rom[5] = 8'h06;
    prev_wait = 0;
    for (int i = 0; i < 6; i++) begin
      mon_q.push_back('{1'b0, rom[i], (i == 0) ? 0 : HOLD + prev_wait + 1 + SETUP});
      prev_wait = (rom[i] == 8'h01) ? CLRW : CMDW;
    end
  endtask

  // Pulse monitor: pops one expectation per lcd_en pulse, checks bus, width, gap and hold
  initial begin : monitor
    exp_t cur;
    bit   in_pulse;
    bit   have_fall;
    int   width;
    int   low_cnt;
    in_pulse = 1'b0; have_fall = 1'b0; width = 0; low_cnt = 0;
    cur = '{1'b0, 8'h00, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_q.delete();
        in_pulse = 1'b0; have_fall = 1'b0; width = 0; low_cnt = 0;
      end else if (lcd_en) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          width = 0;
          chk("pulse_expected", 32'(mon_q.size() > 0), 32'd1);
          if (mon_q.size() > 0) cur = mon_q.pop_front();
          else cur = '{lcd_rs, lcd_data, 0};
          chk("pulse_bus", 32'({lcd_rs, lcd_data}), 32'({cur.rs, cur.data}));
          if (cur.gap != 0 && have_fall) chk("pulse_gap", 32'(low_cnt), 32'(cur.gap));
        end else begin
          chk("pulse_bus_stable", 32'({lcd_rs, lcd_data}), 32'({cur.rs, cur.data}));
        end
        width++;
      end else begin
        if (in_pulse) begin
          chk("pulse_width", 32'(width), 32'(EN));
          in_pulse = 1'b0;
          have_fall = 1'b1;
          low_cnt = 0;
        end
        low_cnt++;
        if (have_fall && low_cnt <= HOLD)
          chk("hold_bus_stable", 32'({lcd_rs, lcd_data}), 32'({cur.rs, cur.data}));
      end
    end
  end

  task automatic wait_init(input string tag);
    int k;
    k = 0;
    while (!init_done && k < 1000) begin
      chk($sformatf("%s_ready_before_init", tag), 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_init_done", tag), 32'(init_done), 32'd1);
    chk($sformatf("%s_ready_after_init", tag), 32'(req_ready), 32'd1);
    chk($sformatf("%s_all_init_written", tag), 32'(mon_q.size()), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!req_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_ready_seen", tag), 32'(req_ready), 32'd1);
  endtask

  // One handshake; checks latch, enable start offset and acceptance-to-ready latency
  task automatic send(input logic rs, input logic [7:0] data, input int wait_cyc, input string tag);
    int k;
    int en_at;
    wait_ready(tag);
    req_valid = 1'b1; req_rs = rs; req_data = data;
    mon_q.push_back('{rs, data, 0});
    @(negedge clk);
    req_valid = 1'b0;
    req_data = 8'($urandom_range(255));
    req_rs = 1'($urandom_range(1));
    chk($sformatf("%s_latched", tag), 32'({lcd_rs, lcd_data}), 32'({rs, data}));
    k = 1; en_at = 0;
    while (!req_ready && k < 500) begin
      @(negedge clk);
      k++;
      if (lcd_en && en_at == 0) en_at = k;
    end
    chk($sformatf("%s_en_start", tag), 32'(en_at), 32'(1 + SETUP));
    chk($sformatf("%s_latency", tag), 32'(k), 32'(1 + SETUP + EN + HOLD + wait_cyc));
  endtask

  initial begin : main
    vec_t vecs[8];
    int   n;
    int   acc;

    vecs[0] = '{1'b1, 8'h41, CMDW};
    vecs[1] = '{1'b0, 8'h02, CLRW};
    vecs[2] = '{1'b0, 8'h80, CMDW};
    vecs[3] = '{1'b0, 8'h01, CLRW};
    vecs[4] = '{1'b0, 8'h03, CLRW};
    vecs[5] = '{1'b0, 8'h04, CMDW};
    vecs[6] = '{1'b1, 8'h01, CMDW};
    vecs[7] = '{1'b0, 8'h00, CMDW};

    repeat (3) @(negedge clk);
    chk("rst_lcd_en", 32'(lcd_en), 32'd0);
    chk("rst_lcd_bus", 32'({lcd_rs, lcd_data}), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    // Power-up and init sequence
    push_init();
    rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (lcd_en) break;
    end
    chk("pwrup_to_first_en", 32'(n), 32'(PWRUP + 1 + SETUP));
    wait_init("init1");

    // Table of single requests, including clear/home classification boundaries
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].rs, vecs[i].data, vecs[i].wait_cyc, $sformatf("vec%0d", i));
    end

    // req_valid held high with changing data: only bytes present on ready cycles are written
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'hA0;
    acc = 0; n = 0;
    while (acc < 3 && n < 400) begin
      if (req_ready) begin
        mon_q.push_back('{req_rs, req_data, 0});
        acc++;
        @(negedge clk);
        n++;
        chk("held_ready_drop", 32'(req_ready), 32'd0);
      end
      req_data = 8'($urandom_range(255));
      req_rs = 1'($urandom_range(1));
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("held_accepted", 32'(acc), 32'd3);
    wait_ready("held_drain");
    chk("held_all_written", 32'(mon_q.size()), 32'd0);

    // Reset during the enable pulse of a data write
    wait_ready("rst_mid");
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    mon_q.push_back('{1'b1, 8'h55, 0});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_pulse_reached", 32'(lcd_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en", 32'(lcd_en), 32'd0);
    chk("async_rst_bus", 32'({lcd_rs, lcd_data}), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    chk("async_rst_init_done", 32'(init_done), 32'd0);
    repeat (2) @(negedge clk);

    // Request pending before init completes: accepted on the first ready cycle only
    push_init();
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
    rst = 1'b0;
    wait_init("init2");
    mon_q.push_back('{1'b1, 8'h5A, 0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("early_req_accepted_first", 32'(req_ready), 32'd0);
    chk("early_req_latched", 32'({lcd_rs, lcd_data}), 32'({1'b1, 8'h5A}));
    wait_ready("early_req_done");
    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(mon_q.size()), 32'd0);
    chk("final_en_low", 32'(lcd_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
